// File: rtl/regfile_sweep_clear.sv
// regfile_sweep_clear: parametrised dual-read, single-write register bank
// for the CPU datapath. A clear request starts a sweep that zeroes one
// entry per cycle while clear_busy is high. Synchronous reset zeroes the
// whole bank in a single cycle. Register 0 can optionally be hardwired to
// zero, and an accepted write can optionally be forwarded to the read ports
// in the same cycle.
module regfile_sweep_clear #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address_w,
    input  logic [DATA_W-1:0] data_in_w,
    input  logic [ADDR_W-1:0] address_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic [ADDR_W-1:0] address_b,
    output logic [DATA_W-1:0] data_out_b,
    output logic              clear_busy,
    output logic              write_err
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pointer;
    logic [DATA_W-1:0] bank [DEPTH];

    logic write_window;
    logic write_accept;
    logic write_drop;
    logic write_to_zero;

    // Decide whether this cycle's write request lands, is dropped, or is
    // silently swallowed by the hardwired zero register.
    always_comb begin
        write_window  = (state == IDLE) && !clear;
        write_accept  = write_enable && write_window;
        write_drop    = write_enable && !write_window;
        write_to_zero = ZERO_REG && (address_w == '0);
    end

    // Sweep controller: clear in IDLE launches a sweep covering every entry
    // once; the exit is taken explicitly on the last entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pointer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= SWEEP;
                        pointer <= '0;
                    end
                end
                SWEEP: begin
                    if (pointer == LAST) begin
                        state   <= IDLE;
                        pointer <= '0;
                    end else begin
                        pointer <= pointer + ADDR_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    pointer <= '0;
                end
            endcase
        end
    end

    // Storage update: reset clears everything at once, the sweep clears one
    // entry per cycle, otherwise an accepted write stores its data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == SWEEP) begin
            bank[pointer] <= '0;
        end else if (write_accept && !write_to_zero) begin
            bank[address_w] <= data_in_w;
        end
    end

    // One-cycle error pulse for every dropped write request.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_err <= 1'b0;
        end else begin
            write_err <= write_drop;
        end
    end

    // Busy flag follows the sweep state so it is high for exactly one
    // cycle per swept entry.
    always_comb begin
        clear_busy = (state == SWEEP);
    end

    // Read port A: masked during a sweep so partially cleared contents are
    // never visible, then zero register, then bypass, then storage.
    always_comb begin
        data_out_a = bank[address_a];
        if (clear_busy) begin
            data_out_a = '0;
        end else if (ZERO_REG && (address_a == '0)) begin
            data_out_a = '0;
        end else if (BYPASS && write_accept && (address_w == address_a)) begin
            data_out_a = data_in_w;
        end
    end

    // Read port B: same priority as port A, fully independent of it.
    always_comb begin
        data_out_b = bank[address_b];
        if (clear_busy) begin
            data_out_b = '0;
        end else if (ZERO_REG && (address_b == '0)) begin
            data_out_b = '0;
        end else if (BYPASS && write_accept && (address_w == address_b)) begin
            data_out_b = data_in_w;
        end
    end

endmodule
